arduino_rx_decoder: RTL and testbench
=====================================

Name: arduino_rx_decoder

Overview:
- Receives the serial key-event stream sent by the Arduino front end, i.e. the direction opposite to the FPGA-to-Arduino link.
- Decodes it into the key inputs consumed by the main circuit: botoes[12:0], right_arrow_pressed, left_arrow_pressed and enter_pressed.
- Frame format is UART 8N1, LSB first, idle high.
- Each received byte is one event: a note press, a note release, an arrow or enter.

Parameters:
CLOCK_FREQ, 50_000_000, frequency of clock in Hz
BAUD, 9600, serial bit rate; DIVISOR = CLOCK_FREQ/BAUD (integer, >= 4)
NUM_NOTES, 13, width of botoes; valid note indices are 0..NUM_NOTES-1

Ports:
clock  input  1  system clock (clock_50M domain)
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line from Arduino, asynchronous to clock
botoes  output  NUM_NOTES  level per note, 1 = held
right_arrow_pressed  output  1  one-cycle pulse
left_arrow_pressed  output  1  one-cycle pulse
enter_pressed  output  1  one-cycle pulse
byte_valid  output  1  one-cycle pulse per accepted byte
byte_data  output  8  last accepted byte, held until the next one
frame_error  output  1  one-cycle pulse, stop bit sampled low
code_error  output  1  one-cycle pulse, byte well-framed but undecodable

Behaviour:
Reset and input sync:
- Reset is asynchronous and active-low (reset=0).
- While reset=0: all outputs are 0, the FSM is in IDLE, and the synchronizer flops are set to 1.
- rx passes through a 2-flop synchronizer (rx_s) before use; all timing below is relative to rx_s.

Bit timing:
- One bit counter runs from 0 to DIVISOR-1.
- A shift register holds 8 bits; a 3-bit index selects the current data bit.

FSM states and transitions:
- IDLE: on a falling edge of rx_s (1 then 0), go to START and clear the bit counter.
- START: count to DIVISOR/2-1, then sample rx_s.
  - If rx_s=1 it was a glitch: return to IDLE, no flags raised.
  - If rx_s=0: go to DATA with index=0.
- DATA: count to DIVISOR-1, sample rx_s into bit[index], increment index.
  - After index 7 is sampled, go to STOP.
- STOP: count to DIVISOR-1, then sample rx_s.
  - If rx_s=1: go to DECODE.
  - If rx_s=0: pulse frame_error, discard the byte, go to WAIT_IDLE.
- DECODE: lasts one cycle; all event outputs update on this edge; then return to IDLE.
- WAIT_IDLE: stay until rx_s=1, which handles a break condition; then go to IDLE. No output activity while here.

Decode of byte b, where op=b[7:5] and idx=b[3:0]:
- op=001: right_arrow_pressed pulse.
- op=010: left_arrow_pressed pulse.
- op=011: enter_pressed pulse.
- op=100 with idx<NUM_NOTES: set botoes[idx]. Setting an already-set note is a no-op, not an error.
- op=101 with idx<NUM_NOTES: clear botoes[idx].
- op=110: clear all of botoes (all-release).
- Any other op, or idx>=NUM_NOTES for op 100/101: code_error pulse. botoes and the arrow/enter pulses are unchanged.
- b[4] is ignored.

Handshake outputs:
- byte_valid pulses and byte_data updates in the DECODE cycle for every well-framed byte, including bytes that raise code_error.
- frame_error and code_error are never asserted in the same cycle.

Latency:
- Event outputs change 1 cycle after the mid-stop-bit sample.
- The first cycle of the next frame can be accepted in the cycle after DECODE.
- Back-to-back frames with no idle gap must decode correctly.

Other boundary rules:
- A reset pulse mid-frame abandons the frame. No pulses are generated for it.
- botoes returns to 0 on reset.
- At most one of the three arrow/enter pulses is high in any cycle.

Test Plan:
1. Bench uses CLOCK_FREQ=16, BAUD=1 (DIVISOR=16). Send 0x83 (press note 3) -> at the DECODE edge: botoes=13'h0008, byte_valid=1 for 1 cycle, byte_data=0x83, no error pulses.
2. Send 0x83, 0x8C, 0xA3 back-to-back with no idle gap -> botoes goes 0x0008, then 0x1008, then 0x1000. Exactly 3 byte_valid pulses, each 160 cycles apart.
3. Send 0x20, 0x40, 0x60 -> right_arrow_pressed, then left_arrow_pressed, then enter_pressed, each high for exactly 1 cycle; botoes unchanged.
4. Send 0x8D (index 13) and 0xE0 (op 111) -> code_error pulses twice, byte_valid pulses twice, botoes unchanged. Then send 0xC0 -> botoes=0.
5. Send a frame whose stop bit is 0, then hold rx low for 40 cycles -> one frame_error pulse, no byte_valid, FSM stays in WAIT_IDLE. After rx returns high, 0x81 decodes normally (botoes[1]=1).
6. Drive a 3-cycle low glitch on rx -> no output activity. Separately, assert reset=0 during DATA of a 0x83 frame -> all outputs 0 immediately; after release the next frame decodes correctly.

Source files
------------

// File: rtl/arduino_rx_decoder.sv
// UART 8N1 receiver for the Arduino key-event stream. Each framed byte is
// decoded into note levels (botoes) and arrow/enter pulses for the main circuit.
module arduino_rx_decoder #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int NUM_NOTES  = 13
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [NUM_NOTES-1:0] botoes,
  output logic                 right_arrow_pressed,
  output logic                 left_arrow_pressed,
  output logic                 enter_pressed,
  output logic                 byte_valid,
  output logic [7:0]           byte_data,
  output logic                 frame_error,
  output logic                 code_error
);

  localparam int DIVISOR = CLOCK_FREQ / BAUD;
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DECODE,
    WAIT_IDLE
  } state_t;

  state_t           state, next_state;
  logic             rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             half_done, full_done;

  // NOTE: reset drives the line flops to the idle level (1) so that leaving
  // reset can never look like a falling start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop load the pre-edge
      // values, so the chain shifts by exactly one stage per clock.
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign half_done = (cnt == HALF_LAST);
  assign full_done = (cnt == FULL_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    next_state = state;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rx_prev && !rx_s) next_state = START;
      end
      START: begin
        if (half_done) begin
          cnt_clr    = 1'b1;
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_done) begin
          cnt_clr = 1'b1;
          if (bit_idx == 3'd7) next_state = STOP;
        end
      end
      STOP: begin
        if (full_done) begin
          cnt_clr    = 1'b1;
          next_state = rx_s ? DECODE : WAIT_IDLE;
        end
      end
      DECODE: begin
        cnt_clr    = 1'b1;
        next_state = IDLE;
      end
      WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_s) next_state = IDLE;
      end
      default: begin
        cnt_clr    = 1'b1;
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (state == START) bit_idx <= 3'd0;
      if (state == DATA && full_done) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  // Event decode: op in bits 7:5, note index in bits 3:0, bit 4 unused.
  logic [2:0]           op;
  logic [3:0]           note_idx;
  logic                 note_ok;
  logic [NUM_NOTES-1:0] note_mask;
  logic [NUM_NOTES-1:0] botoes_next;
  logic                 dec_right, dec_left, dec_enter, dec_code_err;

  assign op        = shift[7:5];
  assign note_idx  = shift[3:0];
  assign note_ok   = ({28'd0, note_idx} < 32'(NUM_NOTES));
  assign note_mask = NUM_NOTES'(1) << note_idx;

  always_comb begin
    botoes_next  = botoes;
    dec_right    = 1'b0;
    dec_left     = 1'b0;
    dec_enter    = 1'b0;
    dec_code_err = 1'b0;
    case (op)
      3'b001: dec_right = 1'b1;
      3'b010: dec_left  = 1'b1;
      3'b011: dec_enter = 1'b1;
      3'b100: begin
        if (note_ok) botoes_next = botoes | note_mask;
        else         dec_code_err = 1'b1;
      end
      3'b101: begin
        if (note_ok) botoes_next = botoes & ~note_mask;
        else         dec_code_err = 1'b1;
      end
      3'b110:  botoes_next  = '0;
      default: dec_code_err = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes              <= '0;
      right_arrow_pressed <= 1'b0;
      left_arrow_pressed  <= 1'b0;
      enter_pressed       <= 1'b0;
      byte_valid          <= 1'b0;
      byte_data           <= 8'h00;
      frame_error         <= 1'b0;
      code_error          <= 1'b0;
    end else begin
      right_arrow_pressed <= 1'b0;
      left_arrow_pressed  <= 1'b0;
      enter_pressed       <= 1'b0;
      byte_valid          <= 1'b0;
      code_error          <= 1'b0;
      frame_error         <= (state == STOP) && full_done && !rx_s;
      if (state == DECODE) begin
        byte_valid          <= 1'b1;
        byte_data           <= shift;
        botoes              <= botoes_next;
        right_arrow_pressed <= dec_right;
        left_arrow_pressed  <= dec_left;
        enter_pressed       <= dec_enter;
        code_error          <= dec_code_err;
      end
    end
  end

endmodule

// File: tb/tb_arduino_rx_decoder.sv
// Self-checking bench for arduino_rx_decoder: serial frames are driven at
// DIVISOR=16 and a scoreboard compares each decoded byte as it appears.
module tb_arduino_rx_decoder;

  localparam int NN   = 13;
  localparam int BITC = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx;
  logic [NN-1:0] botoes;
  logic          right_arrow_pressed, left_arrow_pressed, enter_pressed;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_error, code_error;

  arduino_rx_decoder #(
    .CLOCK_FREQ(16),
    .BAUD      (1),
    .NUM_NOTES (NN)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .rx                 (rx),
    .botoes             (botoes),
    .right_arrow_pressed(right_arrow_pressed),
    .left_arrow_pressed (left_arrow_pressed),
    .enter_pressed      (enter_pressed),
    .byte_valid         (byte_valid),
    .byte_data          (byte_data),
    .frame_error        (frame_error),
    .code_error         (code_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]    b;
    logic [NN-1:0] bot;
    logic [2:0]    ev;    // {right, left, enter}
    logic          cerr;
  } vec_t;

  typedef struct {
    logic [7:0]    b;
    logic [NN-1:0] bot;
    logic [2:0]    ev;
    logic          cerr;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   valid_cnt   = 0;
  int   fe_cnt      = 0;
  int   fe_cyc      = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every byte_valid and polices stray pulses.
  always @(negedge clock) begin
    if (byte_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte_valid: got byte %0h expected none (cycle %0d)", byte_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("byte_data", 32'(byte_data), 32'(e.b));
        check("botoes", 32'(botoes), 32'(e.bot));
        check("events", 32'({right_arrow_pressed, left_arrow_pressed, enter_pressed}), 32'(e.ev));
        check("code_error", 32'(code_error), 32'(e.cerr));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (!byte_valid && (right_arrow_pressed || left_arrow_pressed || enter_pressed || code_error)) begin
      miscompares++;
      $display("FAIL stray_pulse: got {r,l,e,cerr}=%b expected 0000 (cycle %0d)",
               {right_arrow_pressed, left_arrow_pressed, enter_pressed, code_error}, cyc);
    end
    if (frame_error) begin
      fe_cnt++;
      fe_cyc = cyc;
      if (byte_valid || code_error) begin
        miscompares++;
        $display("FAIL frame_error_overlap: got valid=%b cerr=%b expected 0 0", byte_valid, code_error);
      end
    end
  end

  // Drives one frame starting at the current negedge; optionally records
  // the expected decode, due 156 cycles after the start bit is driven.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic push,
                           input logic [NN-1:0] bot, input logic [2:0] ev, input logic cerr);
    if (push) sb.push_back('{b, bot, ev, cerr, cyc + 156});
    rx = 1'b0;
    repeat (BITC) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITC) @(negedge clock);
    end
    rx = stop;
    repeat (BITC) @(negedge clock);
  endtask

  vec_t vecs[17];
  int   start_cyc;
  int   v0;

  initial begin
    // Back-to-back burst, starting from botoes = 0x0008.
    vecs[0]  = '{8'h83, 13'h0008, 3'b000, 1'b0};
    vecs[1]  = '{8'h8C, 13'h1008, 3'b000, 1'b0};
    vecs[2]  = '{8'hA3, 13'h1000, 3'b000, 1'b0};
    vecs[3]  = '{8'h20, 13'h1000, 3'b100, 1'b0};
    vecs[4]  = '{8'h40, 13'h1000, 3'b010, 1'b0};
    vecs[5]  = '{8'h60, 13'h1000, 3'b001, 1'b0};
    vecs[6]  = '{8'h8D, 13'h1000, 3'b000, 1'b1};
    vecs[7]  = '{8'hE0, 13'h1000, 3'b000, 1'b1};
    vecs[8]  = '{8'h90, 13'h1001, 3'b000, 1'b0};
    vecs[9]  = '{8'h8C, 13'h1001, 3'b000, 1'b0};
    vecs[10] = '{8'h00, 13'h1001, 3'b000, 1'b1};
    vecs[11] = '{8'hAF, 13'h1001, 3'b000, 1'b1};
    vecs[12] = '{8'hAC, 13'h0001, 3'b000, 1'b0};
    vecs[13] = '{8'hDF, 13'h0000, 3'b000, 1'b0};
    vecs[14] = '{8'hC0, 13'h0000, 3'b000, 1'b0};
    vecs[15] = '{8'h8A, 13'h0400, 3'b000, 1'b0};
    vecs[16] = '{8'h31, 13'h0400, 3'b100, 1'b0};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_botoes", 32'(botoes), 32'h0);
    check("reset_byte_data", 32'(byte_data), 32'h0);
    check("reset_pulses", 32'({byte_valid, right_arrow_pressed, left_arrow_pressed,
                               enter_pressed, frame_error, code_error}), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Single press of note 3.
    send_byte(8'h83, 1'b1, 1'b1, 13'h0008, 3'b000, 1'b0);
    check("single_byte_valid_width", 32'(byte_valid), 32'h0);
    repeat (10) @(negedge clock);

    foreach (vecs[i]) send_byte(vecs[i].b, 1'b1, 1'b1, vecs[i].bot, vecs[i].ev, vecs[i].cerr);
    repeat (10) @(negedge clock);

    // Stop bit low, line held low: one frame_error then silence until idle.
    v0        = valid_cnt;
    start_cyc = cyc;
    send_byte(8'h55, 1'b0, 1'b0, '0, 3'b000, 1'b0);
    repeat (40) @(negedge clock);
    check("frame_error_count", 32'(fe_cnt), 32'd1);
    check("frame_error_cycle", 32'(fe_cyc), 32'(start_cyc + 155));
    check("frame_error_no_valid", 32'(valid_cnt), 32'(v0));
    rx = 1'b1;
    repeat (20) @(negedge clock);
    send_byte(8'h81, 1'b1, 1'b1, 13'h0402, 3'b000, 1'b0);
    repeat (10) @(negedge clock);

    // Short low glitch must be rejected in START.
    v0 = valid_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_no_valid", 32'(valid_cnt), 32'(v0));
    check("glitch_botoes", 32'(botoes), 32'h0402);
    check("glitch_no_frame_error", 32'(fe_cnt), 32'd1);

    // Reset in the middle of a 0x83 frame abandons it.
    rx = 1'b0;
    repeat (BITC) @(negedge clock);
    rx = 1'b1;
    repeat (30) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset_botoes", 32'(botoes), 32'h0);
    check("midreset_byte_data", 32'(byte_data), 32'h0);
    check("midreset_valid", 32'(byte_valid), 32'h0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    send_byte(8'h83, 1'b1, 1'b1, 13'h0008, 3'b000, 1'b0);

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    check("total_valid", 32'(valid_cnt), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
